// File: rtl/usb_line_pkg.sv
// Shared USB full-speed line-level types and constants for the receive path
// and the transceiver monitor.
package usb_line_pkg;

    localparam int unsigned BIT_CYCLES = 3;
    localparam int unsigned STUFF_LEN  = 6;

    // Encoded as {dp, dn}
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_WAIT_IDLE
    } dec_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SYNC  = 2'd1,
        ERR_STUFF = 2'd2,
        ERR_LINE  = 2'd3
    } err_code_t;

    function automatic line_t classify(input logic dp, input logic dn);
        return line_t'({dp, dn});
    endfunction

endpackage

// File: rtl/usb_line_sync.sv
// Two-flop synchronizer for the raw dp/dn pair, line-state classification and
// edge flag; line_state lags the edge flag by one cycle so phase sampling sees a settled bit.
module usb_line_sync
    import usb_line_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  dp,
    input  logic  dn,
    output line_t line_state,
    output logic  edge_c
);

    logic [1:0] meta;
    line_t      line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 2'b10;
            line_q     <= LS_J;
            line_state <= LS_J;
        end else begin
            meta       <= {dp, dn};
            line_q     <= classify(meta[1], meta[0]);
            line_state <= line_q;
        end
    end

    assign edge_c = (line_q != line_state);

endmodule

// File: rtl/jk_decoder.sv
// USB full-speed receive line decoder: bit-timing recovery, NRZI decode,
// SYNC detection, bit-unstuffing and EOP detection.
module jk_decoder
    import usb_line_pkg::*;
#(
    parameter int unsigned SYNC_MIN  = 7,
    parameter int unsigned IDLE_BITS = 8
) (
    input  logic       clk36,
    input  logic       reset_n,
    input  logic       dp,
    input  logic       dn,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       rx_active,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned          JCNT_W     = $clog2(IDLE_BITS + 1);
    localparam logic [2:0]           SYNC_MIN_L = 3'(SYNC_MIN);
    localparam logic [2:0]           STUFF_L    = 3'(STUFF_LEN);
    localparam logic [1:0]           PHASE_LAST = 2'(BIT_CYCLES - 1);
    localparam logic [JCNT_W-1:0]    IDLE_LAST  = JCNT_W'(IDLE_BITS - 1);

    line_t             line_smp;
    logic              edge_c;
    logic [1:0]        phase;
    logic              strobe_c;
    logic              nrzi_c;
    logic              fail_c;
    err_code_t         fail_code_c;
    dec_state_t        state;
    line_t             prev_jk;
    logic [2:0]        zeros;
    logic [2:0]        ones;
    logic [1:0]        se0cnt;
    logic [JCNT_W-1:0] jcnt;
    logic              se0_seen;

    usb_line_sync u_sync (
        .clk        (clk36),
        .rst_n      (reset_n),
        .dp         (dp),
        .dn         (dn),
        .line_state (line_smp),
        .edge_c     (edge_c)
    );

    // Bit-phase recovery: resync on every line transition
    always_ff @(posedge clk36 or negedge reset_n) begin
        if (!reset_n)                phase <= 2'd0;
        else if (edge_c)             phase <= 2'd0;
        else if (phase == PHASE_LAST) phase <= 2'd0;
        else                         phase <= phase + 2'd1;
    end

    assign strobe_c = (phase == 2'd1);
    assign nrzi_c   = (line_smp == prev_jk);

    // Error classification for the current sample
    always_comb begin
        fail_c      = 1'b0;
        fail_code_c = ERR_NONE;
        case (state)
            ST_SYNC: begin
                if (line_smp == LS_SE0 || line_smp == LS_SE1 || (nrzi_c && zeros < SYNC_MIN_L)) begin
                    fail_c      = 1'b1;
                    fail_code_c = ERR_SYNC;
                end
            end
            ST_DATA: begin
                if (line_smp == LS_SE1) begin
                    fail_c      = 1'b1;
                    fail_code_c = ERR_LINE;
                end else if (line_smp != LS_SE0 && ones == STUFF_L && nrzi_c) begin
                    fail_c      = 1'b1;
                    fail_code_c = ERR_STUFF;
                end
            end
            ST_EOP: begin
                if (line_smp == LS_K || line_smp == LS_SE1 || (line_smp == LS_SE0 && se0cnt == 2'd2)) begin
                    fail_c      = 1'b1;
                    fail_code_c = ERR_LINE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk36 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            prev_jk   <= LS_J;
            zeros     <= 3'd0;
            ones      <= 3'd0;
            se0cnt    <= 2'd0;
            jcnt      <= '0;
            se0_seen  <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            rx_active <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            bit_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            if (strobe_c) begin
                if (fail_c) begin
                    err       <= 1'b1;
                    err_code  <= fail_code_c;
                    rx_active <= 1'b0;
                    state     <= ST_WAIT_IDLE;
                    jcnt      <= '0;
                    se0_seen  <= 1'b0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (line_smp == LS_K) begin
                                prev_jk  <= LS_K;
                                zeros    <= 3'd1;
                                err_code <= ERR_NONE;
                                state    <= ST_SYNC;
                            end else begin
                                prev_jk  <= LS_J;
                            end
                        end
                        ST_SYNC: begin
                            prev_jk <= line_smp;
                            if (!nrzi_c) begin
                                if (zeros != 3'd7) zeros <= zeros + 3'd1;
                            end else begin
                                state     <= ST_DATA;
                                rx_active <= 1'b1;
                                ones      <= 3'd1;
                            end
                        end
                        ST_DATA: begin
                            if (line_smp == LS_SE0) begin
                                state  <= ST_EOP;
                                se0cnt <= 2'd1;
                            end else begin
                                prev_jk <= line_smp;
                                if (ones == STUFF_L) begin
                                    ones <= 3'd0;
                                end else begin
                                    bit_valid <= 1'b1;
                                    bit_out   <= nrzi_c;
                                    ones      <= nrzi_c ? ones + 3'd1 : 3'd0;
                                end
                            end
                        end
                        ST_EOP: begin
                            if (line_smp == LS_SE0) begin
                                se0cnt <= se0cnt + 2'd1;
                            end else begin
                                done      <= 1'b1;
                                rx_active <= 1'b0;
                                prev_jk   <= LS_J;
                                state     <= ST_IDLE;
                            end
                        end
                        ST_WAIT_IDLE: begin
                            case (line_smp)
                                LS_J: begin
                                    if (se0_seen || jcnt == IDLE_LAST) begin
                                        prev_jk <= LS_J;
                                        state   <= ST_IDLE;
                                    end else begin
                                        jcnt <= jcnt + JCNT_W'(1);
                                    end
                                end
                                LS_SE0: begin
                                    se0_seen <= 1'b1;
                                    jcnt     <= '0;
                                end
                                default: begin
                                    se0_seen <= 1'b0;
                                    jcnt     <= '0;
                                end
                            endcase
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_decoder.sv
// Directed bench for jk_decoder: NRZI/stuffing line encoder drives dp/dn,
// expected packet bits go through a queue checked on every strobe.
module tb_jk_decoder;

    localparam logic [1:0] L_SE0 = 2'b00;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_J   = 2'b10;

    logic       clk36;
    logic       reset_n;
    logic       dp;
    logic       dn;
    logic       bit_out;
    logic       bit_valid;
    logic       rx_active;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int   checks;
    int   errors;
    int   n_strobe, n_done, n_err;
    int   b_strobe, b_done, b_err;
    int   last_code;
    int   run;
    logic [1:0] lvl;
    logic exp_b;
    logic exp_q[$];

    jk_decoder dut (
        .clk36     (clk36),
        .reset_n   (reset_n),
        .dp        (dp),
        .dn        (dn),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .rx_active (rx_active),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk36 = 1'b0;
    always #5 clk36 = ~clk36;

    // Output monitor: scoreboard pop on strobes, event counting on done/err
    always @(negedge clk36) begin
        if (reset_n) begin
            if (bit_valid) begin
                n_strobe++;
                checks++;
                assert (rx_active === 1'b1) else begin
                    errors++;
                    $error("FAIL strobe_rx_active observed %0b expected 1", rx_active);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL strobe_extra observed bit %0b expected no strobe", bit_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    assert (bit_out === exp_b) else begin
                        errors++;
                        $error("FAIL strobe_bit observed %0b expected %0b", bit_out, exp_b);
                    end
                end
            end
            if (done) begin
                n_done++;
                checks++;
                assert (rx_active === 1'b0) else begin
                    errors++;
                    $error("FAIL done_rx_active observed %0b expected 0", rx_active);
                end
            end
            if (err) begin
                n_err++;
                last_code = int'(err_code);
                checks++;
                assert (rx_active === 1'b0) else begin
                    errors++;
                    $error("FAIL err_rx_active observed %0b expected 0", rx_active);
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ls, input int cyc);
        {dp, dn} = ls;
        repeat (cyc) @(negedge clk36);
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it
    task automatic nrzi(input logic b, input int cyc);
        if (!b) lvl = (lvl == L_J) ? L_K : L_J;
        drive(lvl, cyc);
    endtask

    task automatic send_sync();
        lvl = L_J;
        repeat (7) nrzi(1'b0, 3);
        nrzi(1'b1, 3);
        run = 1;
    endtask

    // Encoder-side stuffing: a 0 goes on the wire after six consecutive 1s
    task automatic data_bit(input logic b, input int cyc);
        nrzi(b, cyc);
        exp_q.push_back(b);
        run = b ? run + 1 : 0;
        if (run == 6) begin
            nrzi(1'b0, 3);
            run = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] bt);
        for (int i = 0; i < 8; i++) data_bit(bt[i], 3);
    endtask

    task automatic send_eop(input int se0_bits);
        drive(L_SE0, 3 * se0_bits);
        lvl = L_J;
        drive(L_J, 3);
    endtask

    task automatic mark();
        b_strobe = n_strobe;
        b_done   = n_done;
        b_err    = n_err;
    endtask

    task automatic packet_end(input string tag, input int n_bits, input int n_dn, input int n_er);
        lvl = L_J;
        drive(L_J, 12);
        chk({tag, "_strobes"}, n_strobe - b_strobe, n_bits);
        chk({tag, "_done"}, n_done - b_done, n_dn);
        chk({tag, "_err"}, n_err - b_err, n_er);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_rx_active"}, int'(rx_active), 0);
    endtask

    initial begin
        logic [7:0] bt;
        checks    = 0;
        errors    = 0;
        n_strobe  = 0;
        n_done    = 0;
        n_err     = 0;
        last_code = 0;
        run       = 0;
        lvl       = L_J;
        reset_n   = 1'b0;
        {dp, dn}  = L_J;

        repeat (3) @(negedge clk36);
        chk("reset_outputs", int'({bit_out, bit_valid, rx_active, done, err, err_code}), 0);
        reset_n = 1'b1;
        drive(L_J, 12);
        chk("idle_outputs", int'({bit_valid, rx_active, done, err, err_code}), 0);

        // Plain packet, byte C3
        mark();
        send_sync();
        send_byte(8'hC3);
        send_eop(2);
        packet_end("c3", 8, 1, 0);

        // All-ones byte with a stuffed 0 after the fifth data 1
        mark();
        send_sync();
        send_byte(8'hFF);
        send_eop(2);
        packet_end("ff_stuffed", 8, 1, 0);

        // Missing stuff bit: sixth consecutive data 1 is a STUFF error
        mark();
        send_sync();
        for (int i = 0; i < 7; i++) begin
            nrzi(1'b1, 3);
            if (i < 5) exp_q.push_back(1'b1);
        end
        lvl = L_J;
        drive(L_J, 30);
        packet_end("stuff_err", 5, 0, 1);
        chk("stuff_err_code", last_code, 2);
        chk("stuff_err_code_held", int'(err_code), 2);

        // Recovery packet clears err_code
        mark();
        send_sync();
        send_byte(8'h5A);
        send_eop(2);
        packet_end("recover_5a", 8, 1, 0);
        chk("recover_code_cleared", int'(err_code), 0);

        // SE0 after four SYNC zeros
        mark();
        lvl = L_J;
        repeat (4) nrzi(1'b0, 3);
        drive(L_SE0, 6);
        lvl = L_J;
        drive(L_J, 9);
        packet_end("sync_se0", 0, 0, 1);
        chk("sync_se0_code", last_code, 1);

        // Over-long EOP: three bit times of SE0
        mark();
        send_sync();
        send_byte(8'h3C);
        drive(L_SE0, 9);
        lvl = L_J;
        drive(L_J, 30);
        packet_end("eop_long", 8, 0, 1);
        chk("eop_long_code", last_code, 3);

        // A5 with bit times alternating 4 and 2 cycles
        mark();
        send_sync();
        bt = 8'hA5;
        for (int i = 0; i < 8; i++) data_bit(bt[i], (i % 2 == 0) ? 4 : 2);
        send_eop(2);
        packet_end("jitter_a5", 8, 1, 0);

        // Reset pulse in the middle of DATA
        mark();
        send_sync();
        data_bit(1'b0, 3);
        data_bit(1'b1, 3);
        data_bit(1'b1, 3);
        data_bit(1'b1, 3);
        {dp, dn} = L_J;
        reset_n  = 1'b0;
        #1;
        chk("mid_reset_outputs", int'({bit_out, bit_valid, rx_active, done, err, err_code}), 0);
        @(negedge clk36);
        reset_n = 1'b1;
        exp_q.delete();
        lvl = L_J;
        drive(L_J, 12);
        chk("mid_reset_done", n_done - b_done, 0);
        chk("mid_reset_err", n_err - b_err, 0);
        chk("mid_reset_rx_active", int'(rx_active), 0);

        // Post-reset packet of all zeros
        mark();
        send_sync();
        send_byte(8'h00);
        send_eop(2);
        packet_end("zeros_after_reset", 8, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
